// File: rtl/ahb_lite_master_ctrl_pkg.sv
// Shared AHB-Lite encodings, controller state type and command legality check.
package ahb_lite_master_ctrl_pkg;

    localparam int BUS_WIDTH = 32;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    localparam logic [2:0] HSIZE_BYTE     = 3'b000;
    localparam logic [2:0] HSIZE_HALFWORD = 3'b001;
    localparam logic [2:0] HSIZE_WORD     = 3'b010;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [3:0] HPROT_DEFAULT = 4'b0011;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_DONE
    } state_t;

    // A command is illegal when wider than a word or not naturally aligned.
    function automatic logic cmd_illegal(input logic [2:0] size, input logic [1:0] addr_lsb);
        cmd_illegal = (size > HSIZE_WORD) ||
                      ((size == HSIZE_HALFWORD) && addr_lsb[0]) ||
                      ((size == HSIZE_WORD) && (addr_lsb != 2'b00));
    endfunction

endpackage

// File: rtl/ahb_lite_master_ctrl_rr_arbiter.sv
// Two-way round-robin arbiter; holds the last-granted pointer, winner is combinational.
module ahb_lite_rr_arbiter (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       update,
    input  logic       owner,
    output logic [1:0] winner
);

    // Pointer starts at requester 1 so requester 0 wins the first tie.
    logic last;

    // Remember who was served last, updated when a command retires.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last <= 1'b1;
        end else if (update) begin
            last <= owner;
        end
    end

    // On a tie, favour the requester that was not served last.
    always_comb begin
        winner = 2'b00;
        case (req)
            2'b01:   winner = 2'b01;
            2'b10:   winner = 2'b10;
            2'b11:   winner = last ? 2'b01 : 2'b10;
            default: winner = 2'b00;
        endcase
    end

endmodule

// File: rtl/ahb_lite_master_ctrl.sv
// Two-requester AHB-Lite master: arbitrates command ports and runs single NONSEQ transfers.
module ahb_lite_master_ctrl
    import ahb_lite_master_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = BUS_WIDTH
) (
    input  logic                    HCLK,
    input  logic                    HRESET,
    input  logic [1:0]              REQ,
    input  logic [2*ADDR_WIDTH-1:0] REQ_ADDR,
    input  logic [1:0]              REQ_WRITE,
    input  logic [5:0]              REQ_SIZE,
    input  logic [2*DATA_WIDTH-1:0] REQ_WDATA,
    output logic [1:0]              GRANT,
    output logic [1:0]              ACK,
    output logic                    ERR,
    output logic [DATA_WIDTH-1:0]   RDATA,
    output logic [ADDR_WIDTH-1:0]   HADDR,
    output logic                    HWRITE,
    output logic [2:0]              HSIZE,
    output logic [1:0]              HTRANS,
    output logic [DATA_WIDTH-1:0]   HWDATA,
    output logic [2:0]              HBURST,
    output logic [3:0]              HPROT,
    output logic                    HMASTLOCK,
    input  logic                    HREADY,
    input  logic                    HRESP,
    input  logic [DATA_WIDTH-1:0]   HRDATA
);

    state_t                  state, state_d;
    logic                    owner, owner_d;
    logic                    hold, hold_d;
    logic [ADDR_WIDTH-1:0]   lat_addr, lat_addr_d;
    logic                    lat_write, lat_write_d;
    logic [2:0]              lat_size, lat_size_d;
    logic [DATA_WIDTH-1:0]   lat_wdata, lat_wdata_d;
    logic [1:0]              grant_d, ack_d, htrans_d;
    logic                    err_d, hwrite_d;
    logic [DATA_WIDTH-1:0]   rdata_d, hwdata_d;
    logic [ADDR_WIDTH-1:0]   haddr_d;
    logic [2:0]              hsize_d;
    logic                    ptr_update;
    logic [1:0]              winner;
    logic                    sel;
    logic [ADDR_WIDTH-1:0]   sel_addr;
    logic [2:0]              sel_size;
    logic [DATA_WIDTH-1:0]   sel_wdata;
    logic [1:0]              owner_onehot;

    assign HBURST    = HBURST_SINGLE;
    assign HPROT     = HPROT_DEFAULT;
    assign HMASTLOCK = 1'b0;

    assign sel          = winner[1];
    assign sel_addr     = sel ? REQ_ADDR[ADDR_WIDTH +: ADDR_WIDTH] : REQ_ADDR[0 +: ADDR_WIDTH];
    assign sel_size     = sel ? REQ_SIZE[3 +: 3] : REQ_SIZE[0 +: 3];
    assign sel_wdata    = sel ? REQ_WDATA[DATA_WIDTH +: DATA_WIDTH] : REQ_WDATA[0 +: DATA_WIDTH];
    assign owner_onehot = {owner, ~owner};

    ahb_lite_rr_arbiter u_arb (
        .clk    (HCLK),
        .rst    (HRESET),
        .req    (REQ),
        .update (ptr_update),
        .owner  (owner),
        .winner (winner)
    );

    // State register; reset aborts any transfer without acknowledging it.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state <= ST_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next-state and next-output decode; every output is registered below.
    always_comb begin
        state_d     = state;
        owner_d     = owner;
        hold_d      = hold;
        lat_addr_d  = lat_addr;
        lat_write_d = lat_write;
        lat_size_d  = lat_size;
        lat_wdata_d = lat_wdata;
        grant_d     = GRANT;
        ack_d       = ACK;
        err_d       = ERR;
        rdata_d     = RDATA;
        haddr_d     = HADDR;
        hwrite_d    = HWRITE;
        hsize_d     = HSIZE;
        htrans_d    = HTRANS;
        hwdata_d    = HWDATA;
        ptr_update  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (winner != 2'b00) begin
                    owner_d     = sel;
                    lat_addr_d  = sel_addr;
                    lat_write_d = REQ_WRITE[sel];
                    lat_size_d  = sel_size;
                    lat_wdata_d = sel_wdata;
                    grant_d     = winner;
                    if (cmd_illegal(sel_size, sel_addr[1:0])) begin
                        // Extra cycle keeps illegal-command ACK two cycles after sampling.
                        hold_d  = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_ADDR;
                    end
                end
            end
            ST_ADDR: begin
                if (HTRANS == HTRANS_IDLE) begin
                    htrans_d = HTRANS_NONSEQ;
                    haddr_d  = lat_addr;
                    hwrite_d = lat_write;
                    hsize_d  = lat_size;
                end else if (HREADY) begin
                    htrans_d = HTRANS_IDLE;
                    hwdata_d = lat_write ? lat_wdata : '0;
                    state_d  = ST_DATA;
                end
            end
            ST_DATA: begin
                if (HREADY) begin
                    if (!lat_write) begin
                        rdata_d = HRDATA;
                    end
                    err_d    = HRESP;
                    ack_d    = owner_onehot;
                    hwdata_d = '0;
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: begin
                if (hold) begin
                    hold_d = 1'b0;
                end else if (ACK == 2'b00) begin
                    ack_d = owner_onehot;
                    err_d = 1'b1;
                end else begin
                    ack_d      = 2'b00;
                    err_d      = 1'b0;
                    grant_d    = 2'b00;
                    ptr_update = 1'b1;
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output and command-latch registers, all cleared by reset.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            owner     <= 1'b0;
            hold      <= 1'b0;
            lat_addr  <= '0;
            lat_write <= 1'b0;
            lat_size  <= HSIZE_BYTE;
            lat_wdata <= '0;
            GRANT     <= 2'b00;
            ACK       <= 2'b00;
            ERR       <= 1'b0;
            RDATA     <= '0;
            HADDR     <= '0;
            HWRITE    <= 1'b0;
            HSIZE     <= HSIZE_BYTE;
            HTRANS    <= HTRANS_IDLE;
            HWDATA    <= '0;
        end else begin
            owner     <= owner_d;
            hold      <= hold_d;
            lat_addr  <= lat_addr_d;
            lat_write <= lat_write_d;
            lat_size  <= lat_size_d;
            lat_wdata <= lat_wdata_d;
            GRANT     <= grant_d;
            ACK       <= ack_d;
            ERR       <= err_d;
            RDATA     <= rdata_d;
            HADDR     <= haddr_d;
            HWRITE    <= hwrite_d;
            HSIZE     <= hsize_d;
            HTRANS    <= htrans_d;
            HWDATA    <= hwdata_d;
        end
    end

endmodule

// File: tb/tb_ahb_lite_master_ctrl.sv
// Directed bench for ahb_lite_master_ctrl; the bench plays the slave side of the bus.
module tb_ahb_lite_master_ctrl;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic [1:0]  REQ;
    logic [63:0] REQ_ADDR;
    logic [1:0]  REQ_WRITE;
    logic [5:0]  REQ_SIZE;
    logic [63:0] REQ_WDATA;
    logic [1:0]  GRANT, ACK, HTRANS;
    logic        ERR, HWRITE, HMASTLOCK;
    logic [31:0] RDATA, HADDR, HWDATA, HRDATA;
    logic [2:0]  HSIZE, HBURST;
    logic [3:0]  HPROT;
    logic        HREADY, HRESP;

    int checks = 0;
    int errors = 0;
    int lat;
    logic        saw_both;
    logic        saw_nonseq;
    logic [31:0] nonseq_addr;

    ahb_lite_master_ctrl dut (
        .HCLK(HCLK), .HRESET(HRESET), .REQ(REQ), .REQ_ADDR(REQ_ADDR), .REQ_WRITE(REQ_WRITE),
        .REQ_SIZE(REQ_SIZE), .REQ_WDATA(REQ_WDATA), .GRANT(GRANT), .ACK(ACK), .ERR(ERR),
        .RDATA(RDATA), .HADDR(HADDR), .HWRITE(HWRITE), .HSIZE(HSIZE), .HTRANS(HTRANS),
        .HWDATA(HWDATA), .HBURST(HBURST), .HPROT(HPROT), .HMASTLOCK(HMASTLOCK),
        .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA)
    );

    always #10 HCLK = ~HCLK;

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_lane(input int i, input logic [31:0] a, input logic w,
                            input logic [2:0] s, input logic [31:0] d);
        REQ_ADDR[i*32 +: 32]  = a;
        REQ_WRITE[i]          = w;
        REQ_SIZE[i*3 +: 3]    = s;
        REQ_WDATA[i*32 +: 32] = d;
    endtask

    // Latency reported as edges after the sampling edge until ACK is seen.
    task automatic wait_ack(output int l);
        int  n;
        logic got;
        n = 0;
        got = 1'b0;
        saw_nonseq = 1'b0;
        while (!got && n < 40) begin
            tick();
            n++;
            if (GRANT == 2'b11) saw_both = 1'b1;
            if (HTRANS == 2'b10) begin
                saw_nonseq  = 1'b1;
                nonseq_addr = HADDR;
            end
            if (ACK != 2'b00) got = 1'b1;
        end
        check("ack_seen", {63'd0, got}, 64'd1);
        l = n - 1;
    endtask

    initial begin
        HRESET = 1'b1;
        REQ = 2'b00; REQ_ADDR = '0; REQ_WRITE = '0; REQ_SIZE = '0; REQ_WDATA = '0;
        HREADY = 1'b1; HRESP = 1'b0; HRDATA = 32'h0;
        saw_both = 1'b0; saw_nonseq = 1'b0; nonseq_addr = '0;
        tick();
        tick();
        check("rst_htrans", {62'd0, HTRANS}, 64'd0);
        check("rst_grant_ack_err", {59'd0, GRANT, ACK, ERR}, 64'd0);
        check("rst_haddr_rdata", {HADDR, RDATA}, 64'd0);
        check("rst_hwdata_hwrite_hsize", {28'd0, HWDATA, HWRITE, HSIZE}, 64'd0);
        check("const_hburst_hprot_lock", {56'd0, HBURST, HPROT, HMASTLOCK}, {56'd0, 3'b000, 4'b0011, 1'b0});
        HRESET = 1'b0;

        // Tie from reset: alternating grants 0,1,0,1
        set_lane(0, 32'h4, 1'b1, 3'b010, 32'h11111111);
        set_lane(1, 32'h8, 1'b0, 3'b010, 32'h0);
        HRDATA = 32'hcafef00d;
        REQ = 2'b11;
        for (int k = 0; k < 4; k++) begin
            wait_ack(lat);
            check("rr_ack", {62'd0, ACK}, (k % 2 == 0) ? 64'd1 : 64'd2);
            check("rr_lat", lat, 64'd3);
            check("rr_haddr", {32'd0, nonseq_addr}, (k % 2 == 0) ? 64'h4 : 64'h8);
            if (k == 1) check("rr_rdata", {32'd0, RDATA}, 64'hcafef00d);
            tick();
            check("rr_gap_idle", {58'd0, HTRANS, GRANT, ACK}, 64'd0);
        end
        REQ = 2'b00;
        check("rr_never_both", {63'd0, saw_both}, 64'd0);

        // Word write then read at 0x0
        HRDATA = 32'hffddccaa;
        set_lane(0, 32'h0, 1'b1, 3'b010, 32'hffddccaa);
        REQ = 2'b01;
        tick();
        check("wr_grant", {60'd0, GRANT, HTRANS}, {60'd0, 2'b01, 2'b00});
        tick();
        check("wr_addr_phase", {26'd0, HTRANS, HADDR, HWRITE, HSIZE}, {26'd0, 2'b10, 32'h0, 1'b1, 3'b010});
        tick();
        check("wr_data_phase", {30'd0, HTRANS, HWDATA}, {30'd0, 2'b00, 32'hffddccaa});
        check("wr_no_early_ack", {62'd0, ACK}, 64'd0);
        tick();
        check("wr_ack", {61'd0, ACK, ERR}, {61'd0, 2'b01, 1'b0});
        check("wr_rdata_held", {32'd0, RDATA}, 64'hcafef00d);
        REQ = 2'b00;
        tick();
        check("wr_release", {60'd0, GRANT, ACK}, 64'd0);
        set_lane(0, 32'h0, 1'b0, 3'b010, 32'h0);
        REQ = 2'b01;
        wait_ack(lat);
        check("rd_lat", lat, 64'd3);
        check("rd_ack_err", {61'd0, ACK, ERR}, {61'd0, 2'b01, 1'b0});
        check("rd_rdata", {32'd0, RDATA}, 64'hffddccaa);
        REQ = 2'b00;
        tick();

        // Illegal commands: no bus activity, ERR with ACK two cycles after sampling
        set_lane(1, 32'hA, 1'b0, 3'b010, 32'h0);
        REQ = 2'b10;
        wait_ack(lat);
        check("ill_word_lat", lat, 64'd2);
        check("ill_word_ack_err", {61'd0, ACK, ERR}, {61'd0, 2'b10, 1'b1});
        check("ill_word_no_nonseq", {63'd0, saw_nonseq}, 64'd0);
        REQ = 2'b00;
        tick();
        check("ill_err_clear", {61'd0, GRANT, ERR}, 64'd0);
        set_lane(0, 32'h1, 1'b0, 3'b001, 32'h0);
        REQ = 2'b01;
        wait_ack(lat);
        check("ill_half_lat", lat, 64'd2);
        check("ill_half_err", {63'd0, ERR}, 64'd1);
        REQ = 2'b00;
        tick();
        set_lane(0, 32'h0, 1'b0, 3'b011, 32'h0);
        REQ = 2'b01;
        wait_ack(lat);
        check("ill_size_lat", lat, 64'd2);
        check("ill_size_err", {63'd0, ERR}, 64'd1);
        REQ = 2'b00;
        tick();
        set_lane(0, 32'h2, 1'b0, 3'b001, 32'h0);
        REQ = 2'b01;
        wait_ack(lat);
        check("half_ok_lat", lat, 64'd3);
        check("half_ok_err", {63'd0, ERR}, 64'd0);
        check("half_ok_nonseq", {63'd0, saw_nonseq}, 64'd1);
        REQ = 2'b00;
        tick();

        // Two-cycle slave ERROR response, then a normal command
        set_lane(0, 32'h10, 1'b0, 3'b010, 32'h0);
        REQ = 2'b01;
        tick();
        tick();
        tick();
        check("err_in_data_phase", {60'd0, HTRANS, ACK}, 64'd0);
        HREADY = 1'b0; HRESP = 1'b1;
        tick();
        check("err_cycle1_no_ack", {62'd0, ACK}, 64'd0);
        HREADY = 1'b1;
        tick();
        check("err_ack", {61'd0, ACK, ERR}, {61'd0, 2'b01, 1'b1});
        HRESP = 1'b0;
        REQ = 2'b00;
        tick();
        set_lane(1, 32'h14, 1'b1, 3'b010, 32'h55aa55aa);
        REQ = 2'b10;
        wait_ack(lat);
        check("post_err_lat", lat, 64'd3);
        check("post_err_ack", {61'd0, ACK, ERR}, {61'd0, 2'b10, 1'b0});
        REQ = 2'b00;
        tick();

        // Three wait states in address phase and three in data phase
        set_lane(0, 32'h20, 1'b1, 3'b010, 32'h12345678);
        REQ = 2'b01;
        lat = 0;
        tick(); lat++;
        tick(); lat++;
        check("ws_nonseq", {62'd0, HTRANS}, 64'd2);
        HREADY = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick(); lat++;
            check("ws_addr_hold", {30'd0, HTRANS, HADDR}, {30'd0, 2'b10, 32'h20});
        end
        HREADY = 1'b1;
        tick(); lat++;
        check("ws_data_start", {30'd0, HTRANS, HWDATA}, {30'd0, 2'b00, 32'h12345678});
        HREADY = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick(); lat++;
            check("ws_data_hold", {30'd0, ACK, HWDATA}, {30'd0, 2'b00, 32'h12345678});
        end
        HREADY = 1'b1;
        tick(); lat++;
        check("ws_ack", {62'd0, ACK}, 64'd1);
        check("ws_lat", lat - 1, 64'd9);
        REQ = 2'b00;
        tick();

        // Reset during data phase, then a tie goes to requester 0
        set_lane(0, 32'h30, 1'b1, 3'b010, 32'hdeadbeef);
        REQ = 2'b01;
        tick();
        tick();
        tick();
        check("mid_data_phase", {32'd0, HWDATA}, 64'hdeadbeef);
        HREADY = 1'b0;
        #2;
        HRESET = 1'b1;
        #1;
        check("mid_rst_bus", {30'd0, HTRANS, HWDATA}, 64'd0);
        check("mid_rst_ctl", {59'd0, GRANT, ACK, ERR}, 64'd0);
        check("mid_rst_addr_rdata", {HADDR, RDATA}, 64'd0);
        set_lane(1, 32'h40, 1'b0, 3'b010, 32'h0);
        REQ = 2'b11;
        HREADY = 1'b1;
        tick();
        tick();
        check("mid_rst_no_ack", {62'd0, ACK}, 64'd0);
        HRESET = 1'b0;
        wait_ack(lat);
        check("post_rst_tie", {62'd0, ACK}, 64'd1);
        check("post_rst_lat", lat, 64'd3);
        REQ = 2'b00;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
